// File: rtl/drive_rom_sched_pkg.sv
// Shared types and constants for the drive ROM time-division scheduler.
// Holds the drive id type, the drive-count limit and a constant clog2 helper.
package drive_sched_pkg;

    localparam int MAX_DRIVES = 4;

    typedef logic [1:0] drv_id_t;

    // Evaluated at elaboration time to size counters; never returns less than 1 bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/drive_rom_sched_if.sv
// Shared ROM port between the drive scheduler (master) and the ROM BRAM/SDRAM (slave).
// rom_rd is a one-clk strobe with no back-pressure: rom_addr/rom_id are valid while rom_rd=1,
// and rom_data is valid exactly ROM_LAT clks after the strobe; there is no ready signal.
interface drive_rom_sched_if #(
    parameter int ROM_AW = 15
);
    import drive_sched_pkg::*;

    logic [ROM_AW-1:0] rom_addr;
    drv_id_t           rom_id;
    logic              rom_rd;
    logic [7:0]        rom_data;

    modport master (output rom_addr, output rom_id, output rom_rd, input rom_data);
    modport slave  (input rom_addr, input rom_id, input rom_rd, output rom_data);

endinterface

// File: rtl/drive_rom_sched_ret_pipe.sv
// Return pipeline: delays {valid, id} of each ROM read by ROM_LAT clks so the tail
// lines up with rom_data and selects which drive's hold register captures it.
module rom_ret_pipe
    import drive_sched_pkg::*;
#(
    parameter int ROM_LAT = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    in_valid,
    input  drv_id_t in_id,
    output logic    wr_en,
    output drv_id_t wr_id
);

    logic [ROM_LAT-1:0] vld;
    drv_id_t            ids [ROM_LAT];

    // Only the valid bits are reset; ids are don't-care while their valid bit is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int k = 1; k < ROM_LAT; k++) vld[k] <= vld[k-1];
        end
        ids[0] <= in_id;
        for (int k = 1; k < ROM_LAT; k++) ids[k] <= ids[k-1];
    end

    assign wr_en = vld[ROM_LAT-1];
    assign wr_id = ids[ROM_LAT-1];

endmodule

// File: rtl/drive_rom_sched.sv
// Time-division scheduler: generates per-drive 1 MHz ph2 strobes from the system clock and
// gives each drive a fixed, collision-free slot on one shared ROM port with held return data.
module drive_rom_sched
    import drive_sched_pkg::*;
#(
    parameter  int NDRIVES = 2,
    parameter  int CLK_DIV = 32,
    parameter  int ROM_AW  = 15,
    parameter  int ROM_LAT = 2,
    localparam int CNT_W   = clog2(CLK_DIV)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pause,
    input  logic [NDRIVES-1:0]        drv_en,
    output logic [NDRIVES-1:0]        ph2_r,
    output logic [NDRIVES-1:0]        ph2_f,
    input  logic [NDRIVES*ROM_AW-1:0] drv_rom_addr,
    output logic [NDRIVES*8-1:0]      drv_rom_data,
    drive_rom_sched_if.master         rom,
    output logic [CNT_W-1:0]          dbg_cnt
);

    localparam int SLOT = CLK_DIV / NDRIVES;
    localparam int HALF = CLK_DIV / 2;

    if ((NDRIVES < 1) || (NDRIVES > MAX_DRIVES) || (ROM_LAT < 1) || (ROM_LAT > 4) ||
        ((CLK_DIV % 2) != 0) || (CLK_DIV < 2 * NDRIVES * (ROM_LAT + 2))) begin : g_param_guard
        $error("drive_rom_sched: CLK_DIV/NDRIVES/ROM_LAT combination cannot give collision-free slots");
    end

    logic [CNT_W-1:0]   cnt;
    logic [NDRIVES-1:0] r_hit;
    logic [NDRIVES-1:0] f_hit;
    logic [NDRIVES-1:0] i_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!pause) begin
            cnt <= (cnt == CNT_W'(CLK_DIV - 1)) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign dbg_cnt = cnt;

    // Each drive's phase points are constants offset by its slot base, all modulo CLK_DIV.
    for (genvar i = 0; i < NDRIVES; i++) begin : g_hit
        assign r_hit[i] = (cnt == CNT_W'(i * SLOT));
        assign f_hit[i] = (cnt == CNT_W'((i * SLOT + HALF) % CLK_DIV));
        assign i_hit[i] = (cnt == CNT_W'((i * SLOT + 2) % CLK_DIV));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph2_r <= '0;
            ph2_f <= '0;
        end else begin
            ph2_r <= pause ? '0 : (r_hit & drv_en);
            ph2_f <= pause ? '0 : (f_hit & drv_en);
        end
    end

    logic              issue;
    drv_id_t           issue_id;
    logic [ROM_AW-1:0] issue_addr;

    // Slot bases are distinct, so at most one drive can match in any clk.
    always_comb begin
        issue      = 1'b0;
        issue_id   = '0;
        issue_addr = '0;
        for (int i = 0; i < NDRIVES; i++) begin
            if (i_hit[i] && drv_en[i] && !pause) begin
                issue      = 1'b1;
                issue_id   = drv_id_t'(i);
                issue_addr = drv_rom_addr[i*ROM_AW +: ROM_AW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom.rom_rd   <= 1'b0;
            rom.rom_addr <= '0;
            rom.rom_id   <= '0;
        end else begin
            rom.rom_rd <= issue;
            if (issue) begin
                rom.rom_addr <= issue_addr;
                rom.rom_id   <= issue_id;
            end
        end
    end

    logic    wr_en;
    drv_id_t wr_id;

    rom_ret_pipe #(
        .ROM_LAT (ROM_LAT)
    ) u_ret_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_valid (rom.rom_rd),
        .in_id    (rom.rom_id),
        .wr_en    (wr_en),
        .wr_id    (wr_id)
    );

    logic [7:0] hold [NDRIVES];

    // Hold registers keep the last fetched byte so the CPU sees stable data until its ph2_f.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NDRIVES; i++) begin
            if (reset) begin
                hold[i] <= 8'hFF;
            end else if (wr_en && (wr_id == drv_id_t'(i))) begin
                hold[i] <= rom.rom_data;
            end
        end
    end

    for (genvar i = 0; i < NDRIVES; i++) begin : g_out
        assign drv_rom_data[i*8 +: 8] = hold[i];
    end

endmodule

// File: tb/tb_drive_rom_sched.sv
// Bench for drive_rom_sched: a 2-drive/32-div/lat-2 instance and a 4-drive/64-div/lat-4
// instance run side by side against a cycle model, ROM models and an issue scoreboard.
module tb_drive_rom_sched;
    import drive_sched_pkg::*;

    localparam int AW = 15;
    localparam int NDRV [2] = '{2, 4};
    localparam int DIVS [2] = '{32, 64};
    localparam int LATS [2] = '{2, 4};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic pause;

    logic [1:0]      en2;
    logic [3:0]      en4;
    logic [2*AW-1:0] addr2;
    logic [4*AW-1:0] addr4;
    logic [1:0]      r2, f2;
    logic [3:0]      r4, f4;
    logic [15:0]     data2;
    logic [31:0]     data4;
    logic [4:0]      cnt2;
    logic [5:0]      cnt4;

    drive_rom_sched_if #(.ROM_AW(AW)) bus2 ();
    drive_rom_sched_if #(.ROM_AW(AW)) bus4 ();

    drive_rom_sched #(.NDRIVES(2), .CLK_DIV(32), .ROM_AW(AW), .ROM_LAT(2)) dut2 (
        .clk (clk), .reset (reset), .pause (pause), .drv_en (en2),
        .ph2_r (r2), .ph2_f (f2), .drv_rom_addr (addr2), .drv_rom_data (data2),
        .rom (bus2.master), .dbg_cnt (cnt2)
    );

    drive_rom_sched #(.NDRIVES(4), .CLK_DIV(64), .ROM_AW(AW), .ROM_LAT(4)) dut4 (
        .clk (clk), .reset (reset), .pause (pause), .drv_en (en4),
        .ph2_r (r4), .ph2_f (f4), .drv_rom_addr (addr4), .drv_rom_data (data4),
        .rom (bus4.master), .dbg_cnt (cnt4)
    );

    // ROM models: data = addr[7:0]^A5, present only in the cycle ROM_LAT clks after rom_rd.
    logic [7:0] rp2 [2];
    logic [7:0] rp4 [4];

    always @(posedge clk) begin
        rp2[0] <= bus2.rom_rd ? (bus2.rom_addr[7:0] ^ 8'hA5) : 8'h00;
        rp2[1] <= rp2[0];
        rp4[0] <= bus4.rom_rd ? (bus4.rom_addr[7:0] ^ 8'hA5) : 8'h00;
        for (int k = 1; k < 4; k++) rp4[k] <= rp4[k-1];
    end

    assign bus2.rom_data = rp2[1];
    assign bus4.rom_data = rp4[3];

    // ---------------- scoreboard / model state ----------------
    typedef struct {
        int         d;
        int         left;
        int         id;
        logic [7:0] data;
    } wb_t;

    logic [17:0] exp_q [$];
    wb_t         pend [$];
    int          mc [2];
    logic [7:0]  hold_m [2][4];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one clk with model prediction and checks ----------------
    task automatic tick();
        logic [3:0]    er [2];
        logic [3:0]    ef [2];
        logic [3:0]    en_v;
        logic [AW-1:0] a;
        logic [17:0]   e;
        logic          rd;
        int            slot;
        int            half;
        wb_t           keep [$];

        if (reset) begin
            pend.delete();
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 4; i++) hold_m[d][i] = 8'hFF;
        end else begin
            foreach (pend[k]) begin
                pend[k].left--;
                if (pend[k].left == 0) hold_m[pend[k].d][pend[k].id] = pend[k].data;
                else keep.push_back(pend[k]);
            end
            pend = keep;
        end

        for (int d = 0; d < 2; d++) begin
            en_v  = (d == 0) ? {2'b00, en2} : en4;
            slot  = DIVS[d] / NDRV[d];
            half  = DIVS[d] / 2;
            er[d] = '0;
            ef[d] = '0;
            for (int i = 0; i < NDRV[d]; i++) begin
                if (!reset && !pause && en_v[i]) begin
                    if (mc[d] == i * slot) er[d][i] = 1'b1;
                    if (mc[d] == (i * slot + half) % DIVS[d]) ef[d][i] = 1'b1;
                    if (mc[d] == (i * slot + 2) % DIVS[d]) begin
                        a = (d == 0) ? addr2[i*AW +: AW] : addr4[i*AW +: AW];
                        exp_q.push_back({d[0], i[1:0], a});
                        pend.push_back('{d, LATS[d] + 1, i, a[7:0] ^ 8'hA5});
                    end
                end
            end
            mc[d] = reset ? 0 : (pause ? mc[d] : (mc[d] + 1) % DIVS[d]);
        end

        @(posedge clk);
        @(negedge clk);

        check("cnt2", 64'(cnt2), 64'(mc[0]));
        check("cnt4", 64'(cnt4), 64'(mc[1]));
        check("ph2_r2", 64'(r2), 64'(er[0][1:0]));
        check("ph2_f2", 64'(f2), 64'(ef[0][1:0]));
        check("ph2_r4", 64'(r4), 64'(er[1]));
        check("ph2_f4", 64'(f4), 64'(ef[1]));

        for (int d = 0; d < 2; d++) begin
            rd = (d == 0) ? bus2.rom_rd : bus4.rom_rd;
            if (rd) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h3FFFF;
                if (d == 0) check("rom_issue2", 64'({1'b0, bus2.rom_id, bus2.rom_addr}), 64'(e));
                else        check("rom_issue4", 64'({1'b1, bus4.rom_id, bus4.rom_addr}), 64'(e));
            end
        end
        check("rom_rd_missing", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        check("hold2", 64'(data2), 64'({hold_m[0][1], hold_m[0][0]}));
        check("hold4", 64'(data4), 64'({hold_m[1][3], hold_m[1][2], hold_m[1][1], hold_m[1][0]}));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        pause = 1'b0;
        en2   = 2'b11;
        en4   = 4'b1111;
        addr2 = {15'h0012, 15'h7F00};
        addr4 = {15'h4444, 15'h3333, 15'h2222, 15'h1111};
        mc[0] = 0;
        mc[1] = 0;

        repeat (3) tick();
        check("reset_hold2", 64'(data2), 64'hFFFF);
        check("reset_cnt2", 64'(cnt2), 64'd0);

        // Both drives running: strobe pattern and first fetches.
        reset = 1'b0;
        repeat (64) tick();
        check("d0_data_a5", 64'(data2[7:0]), 64'hA5);
        check("d1_data_b7", 64'(data2[15:8]), 64'hB7);

        // Drive 1 disabled: its hold register must keep B7 despite a new address.
        en2   = 2'b01;
        addr2 = {15'h0055, 15'h0101};
        repeat (128) tick();
        check("d1_frozen", 64'(data2[15:8]), 64'hB7);
        check("d0_new", 64'(data2[7:0]), 64'hA4);

        en2 = 2'b11;
        repeat (48) tick();
        check("d1_resume", 64'(data2[15:8]), 64'hF0);

        // Pause at cnt 5 while drive 0's cnt-2 read is still in flight.
        addr2[14:0] = 15'h00F0;
        for (int k = 0; k < 40 && mc[0] != 0; k++) tick();
        for (int k = 0; k < 40 && mc[0] != 5; k++) tick();
        check("pause_start_cnt", 64'(cnt2), 64'd5);
        pause = 1'b1;
        repeat (10) tick();
        check("pause_cnt_frozen", 64'(cnt2), 64'd5);
        check("pause_writeback", 64'(data2[7:0]), 64'h55);
        pause = 1'b0;
        repeat (3) tick();
        check("pause_resume_cnt", 64'(cnt2), 64'd8);

        // Reset one clk after drive 0's rom_rd: the in-flight read must be discarded.
        addr2[14:0] = 15'h0077;
        for (int k = 0; k < 40 && mc[0] != 0; k++) tick();
        for (int k = 0; k < 40 && mc[0] != 3; k++) tick();
        check("rd_before_reset", 64'({bus2.rom_rd, bus2.rom_id}), 64'({1'b1, 2'd0}));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_discard", 64'(data2), 64'hFFFF);
        check("reset_cnt_zero", 64'(cnt2), 64'd0);

        repeat (64) tick();
        check("final_data2", 64'(data2), 64'hF0D2);
        check("final_data4", 64'(data4), 64'hE19687B4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
